hazard_controller: RTL and testbench

Central hazard and sequencing controller for the 5-stage display-processor pipeline (fetch, decode, execute, memory, writeback).
- Generates the stall and flush controls consumed by each stage register, including the decode stage's d_stall/d_flush.
- Generates execute-stage forwarding selects.
- Sequences a post-reset pipeline purge.
- Holds the pipeline during variable-latency VRAM/memory accesses, with a timeout watchdog.

---
 rtl/hazard_controller_if.sv | 60 ++++++
 rtl/hazard_controller.sv | 201 ++++++++++++++++++++
 tb/tb_hazard_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle for the hazard controller: stage register tags in,
// stall/flush/forward controls out. Perf ports exist with HAZARD_PERF_CNT_EN.
interface hazard_controller_if;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic [4:0]  e_rs1;
    logic [4:0]  e_rs2;
    logic [4:0]  e_rd;
    logic        e_is_load;
    logic        e_pc_src;
    logic [4:0]  m_rd;
    logic        m_reg_write;
    logic [4:0]  w_rd;
    logic        w_reg_write;
    logic        m_mem_req;
    logic        m_mem_ready;
    logic        f_stall;
    logic        d_stall;
    logic        e_stall;
    logic        m_stall;
    logic        d_flush;
    logic        e_flush;
    logic        w_flush;
    logic [1:0]  e_forward_a;
    logic [1:0]  e_forward_b;
    logic        mem_timeout;
    logic        busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    modport master (
        output d_rs1, d_rs2, e_rs1, e_rs2, e_rd,
        output e_is_load, e_pc_src,
        output m_rd, m_reg_write, w_rd, w_reg_write,
        output m_mem_req, m_mem_ready,
        input  f_stall, d_stall, e_stall, m_stall,
        input  d_flush, e_flush, w_flush,
        input  e_forward_a, e_forward_b,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles, flush_events,
`endif
        input  mem_timeout, busy
    );

    modport slave (
        input  d_rs1, d_rs2, e_rs1, e_rs2, e_rd,
        input  e_is_load, e_pc_src,
        input  m_rd, m_reg_write, w_rd, w_reg_write,
        input  m_mem_req, m_mem_ready,
        output f_stall, d_stall, e_stall, m_stall,
        output d_flush, e_flush, w_flush,
        output e_forward_a, e_forward_b,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles, flush_events,
`endif
        output mem_timeout, busy
    );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush/forward control with post-reset purge and memory-wait watchdog.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
    parameter int INIT_FLUSH_CYCLES = 4,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave hz
);
    localparam int MAXC = (TIMEOUT_CYCLES > INIT_FLUSH_CYCLES) ?
                          TIMEOUT_CYCLES : INIT_FLUSH_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INIT_LD = CW'(INIT_FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_WAIT,
        S_ERROR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_timeout;
    logic          w_timeout_next;

    logic w_lu;
    logic w_mem_wait;
    logic w_in_init;
    logic w_hold;
    logic w_eval;
    logic w_f_stall;
    logic w_d_stall;
    logic w_e_stall;
    logic w_m_stall;
    logic w_d_flush;
    logic w_e_flush;
    logic w_w_flush;
    logic w_busy;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        if (m_we && m_rd != 5'd0 && m_rd == rs)
            return 2'b10;
        else if (w_we && w_rd != 5'd0 && w_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign w_lu = hz.e_is_load && hz.e_rd != 5'd0 &&
                  (hz.e_rd == hz.d_rs1 || hz.e_rd == hz.d_rs2);
    assign w_mem_wait = hz.m_mem_req && !hz.m_mem_ready;

    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = r_timeout;
        unique case (r_state)
            S_INIT: begin
                if (r_cnt == '0)
                    w_next = S_RUN;
                else
                    w_cnt_next = r_cnt - 1'b1;
            end
            S_RUN: begin
                if (w_mem_wait) begin
                    w_next     = S_WAIT;
                    w_cnt_next = '0;
                end
            end
            S_WAIT: begin
                if (hz.m_mem_ready) begin
                    w_next = S_RUN;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LAST) begin
                    w_next         = S_ERROR;
                    w_timeout_next = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_ERROR: begin
                w_next = S_ERROR;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_cnt     <= INIT_LD;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    // A RUN request that misses ready stalls immediately; a ready seen in
    // WAIT releases immediately, so both edges are decided combinationally.
    assign w_in_init = reset || r_state == S_INIT;
    assign w_hold = !reset && (r_state == S_ERROR ||
                    (r_state == S_WAIT && !hz.m_mem_ready) ||
                    (r_state == S_RUN && w_mem_wait));
    assign w_eval = !reset && (
                    (r_state == S_RUN && !w_mem_wait) ||
                    (r_state == S_WAIT && hz.m_mem_ready));

    always_comb begin
        w_f_stall = 1'b0;
        w_d_stall = 1'b0;
        w_e_stall = 1'b0;
        w_m_stall = 1'b0;
        w_d_flush = 1'b0;
        w_e_flush = 1'b0;
        w_w_flush = 1'b0;
        w_busy    = 1'b0;
        unique case (1'b1)
            w_in_init: begin
                w_f_stall = 1'b1;
                w_d_flush = 1'b1;
                w_e_flush = 1'b1;
                w_w_flush = 1'b1;
                w_busy    = 1'b1;
            end
            w_hold: begin
                w_f_stall = 1'b1;
                w_d_stall = 1'b1;
                w_e_stall = 1'b1;
                w_m_stall = 1'b1;
                w_w_flush = 1'b1;
                w_busy    = 1'b1;
            end
            w_eval: begin
                w_f_stall = w_lu;
                w_d_stall = w_lu;
                w_d_flush = hz.e_pc_src;
                w_e_flush = w_lu || hz.e_pc_src;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    assign hz.f_stall     = w_f_stall;
    assign hz.d_stall     = w_d_stall;
    assign hz.e_stall     = w_e_stall;
    assign hz.m_stall     = w_m_stall;
    assign hz.d_flush     = w_d_flush;
    assign hz.e_flush     = w_e_flush;
    assign hz.w_flush     = w_w_flush;
    assign hz.busy        = w_busy;
    assign hz.mem_timeout = r_timeout && !reset;

    assign hz.e_forward_a = fwd_sel(hz.e_rs1, hz.m_rd, hz.m_reg_write,
                                    hz.w_rd, hz.w_reg_write);
    assign hz.e_forward_b = fwd_sel(hz.e_rs2, hz.m_rd, hz.m_reg_write,
                                    hz.w_rd, hz.w_reg_write);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;
    logic        w_cnt_stall;
    logic        w_cnt_flush;

    assign w_cnt_stall = !reset && w_f_stall &&
                         (r_state == S_RUN || r_state == S_WAIT);
    assign w_cnt_flush = !reset && r_state == S_RUN && hz.e_pc_src;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_cnt_stall && r_stall_cycles != 32'hFFFF_FFFF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_cnt_flush && r_flush_events != 32'hFFFF_FFFF)
                r_flush_events <= r_flush_events + 32'd1;
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_events = r_flush_events;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Vector-table and scoreboard bench for hazard_controller
// (INIT_FLUSH_CYCLES=4, TIMEOUT_CYCLES=8).
module tb_hazard_controller;
    logic clk;
    logic reset;

    hazard_controller_if hz();

    hazard_controller #(
        .INIT_FLUSH_CYCLES(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
        logic       ld, pc, m_rw, w_rw, req, rdy;
    } in_t;

    typedef struct {
        in_t         in;
        logic [12:0] exp;
        string       name;
    } vec_t;

    // {f,d,e,m stall}{d,e,w flush}{fwd_a}{fwd_b}{timeout}{busy}
    localparam logic [12:0] O_RUN  = 13'b0000_000_00_00_0_0;
    localparam logic [12:0] O_INIT = 13'b1000_111_00_00_0_1;
    localparam logic [12:0] O_WAIT = 13'b1111_001_00_00_0_1;
    localparam logic [12:0] O_ERR  = 13'b1111_001_00_00_1_1;
    localparam logic [12:0] O_LU   = 13'b1100_010_00_00_0_0;
    localparam logic [12:0] O_BR   = 13'b0000_110_00_00_0_0;
    localparam logic [12:0] O_LUBR = 13'b1100_110_00_00_0_0;
    localparam logic [12:0] O_FA10 = 13'b0000_000_10_00_0_0;
    localparam logic [12:0] O_FA01 = 13'b0000_000_01_00_0_0;
    localparam logic [12:0] O_FB01 = 13'b0000_000_00_01_0_0;
    localparam logic [12:0] O_FB10 = 13'b0000_000_00_10_0_0;

    vec_t        tbl[$];
    logic [12:0] expq[$];
    string       nameq[$];
    int          total = 0;
    int          bad = 0;

    function automatic in_t z();
        in_t v;
        v.rst = 1'b0;
        v.d_rs1 = '0; v.d_rs2 = '0; v.e_rs1 = '0; v.e_rs2 = '0;
        v.e_rd = '0; v.m_rd = '0; v.w_rd = '0;
        v.ld = 1'b0; v.pc = 1'b0; v.m_rw = 1'b0; v.w_rw = 1'b0;
        v.req = 1'b0; v.rdy = 1'b0;
        return v;
    endfunction

    task automatic add(input in_t v, input logic [12:0] e,
                       input string n);
        vec_t r;
        r.in = v;
        r.exp = e;
        r.name = n;
        tbl.push_back(r);
    endtask

    task automatic drive(input in_t v);
        reset          = v.rst;
        hz.d_rs1       = v.d_rs1;
        hz.d_rs2       = v.d_rs2;
        hz.e_rs1       = v.e_rs1;
        hz.e_rs2       = v.e_rs2;
        hz.e_rd        = v.e_rd;
        hz.e_is_load   = v.ld;
        hz.e_pc_src    = v.pc;
        hz.m_rd        = v.m_rd;
        hz.m_reg_write = v.m_rw;
        hz.w_rd        = v.w_rd;
        hz.w_reg_write = v.w_rw;
        hz.m_mem_req   = v.req;
        hz.m_mem_ready = v.rdy;
    endtask

    task automatic step(input in_t v, input logic [12:0] e,
                        input string n);
        logic [12:0] got;
        logic [12:0] want;
        string       nm;
        @(posedge clk);
        #1;
        drive(v);
        expq.push_back(e);
        nameq.push_back(n);
        @(negedge clk);
        got = {hz.f_stall, hz.d_stall, hz.e_stall, hz.m_stall,
               hz.d_flush, hz.e_flush, hz.w_flush,
               hz.e_forward_a, hz.e_forward_b,
               hz.mem_timeout, hz.busy};
        want = expq.pop_front();
        nm = nameq.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, got, want);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i])
            step(tbl[i].in, tbl[i].exp, tbl[i].name);
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        in_t v;
        v = z();
        v.rst = 1'b1;
        drive(v);

        // reset, purge, hazards, forwarding, short memory wait
        v = z(); v.rst = 1'b1;
        add(v, O_INIT, "reset");
        v = z();
        for (int i = 0; i < 4; i++)
            add(v, O_INIT, "init");
        add(v, O_RUN, "run");
        v = z(); v.ld = 1; v.e_rd = 5; v.d_rs2 = 5;
        add(v, O_LU, "load_use");
        v.e_rd = 0; v.d_rs2 = 0;
        add(v, O_RUN, "load_rd0");
        v = z(); v.e_rs1 = 7; v.m_rd = 7; v.m_rw = 1;
        v.w_rd = 7; v.w_rw = 1;
        add(v, O_FA10, "fwd_a_mem");
        v.m_rw = 0;
        add(v, O_FA01, "fwd_a_wb");
        v.e_rs1 = 0;
        add(v, O_RUN, "fwd_a_x0");
        v = z(); v.e_rs2 = 3; v.w_rd = 3; v.w_rw = 1;
        add(v, O_FB01, "fwd_b_wb");
        v = z(); v.e_rs2 = 9; v.m_rd = 9; v.m_rw = 1;
        v.w_rd = 9; v.w_rw = 1;
        add(v, O_FB10, "fwd_b_prio");
        v = z(); v.pc = 1;
        add(v, O_BR, "branch");
        v.ld = 1; v.e_rd = 4; v.d_rs1 = 4;
        add(v, O_LUBR, "lu_branch");
        v = z(); v.req = 1;
        add(v, O_WAIT, "wait_enter");
        v.pc = 1;
        add(v, O_WAIT, "wait_branch");
        v.pc = 0;
        add(v, O_WAIT, "wait_3");
        v.rdy = 1;
        add(v, O_RUN, "wait_release");
        v = z();
        add(v, O_RUN, "back_run");
        v.req = 1; v.rdy = 1;
        add(v, O_RUN, "zero_lat");
        run_tbl();

        // watchdog expiry, ERROR hold, recovery by reset
        v = z(); v.req = 1;
        step(v, O_WAIT, "to_enter");
        for (int i = 0; i < 8; i++)
            step(v, O_WAIT, "to_wait");
        v.rdy = 1;
        step(v, O_ERR, "err_rdy");
        v = z();
        step(v, O_ERR, "err_hold");
        v.rst = 1;
        step(v, O_INIT, "err_reset");
        v = z();
        for (int i = 0; i < 4; i++)
            step(v, O_INIT, "reinit");
        step(v, O_RUN, "rerun");

        // reset in the middle of a wait, ready ignored during INIT
        v = z(); v.req = 1;
        add(v, O_WAIT, "mw_enter");
        add(v, O_WAIT, "mw_wait");
        v.rst = 1;
        add(v, O_INIT, "mw_reset");
        v = z(); v.req = 1; v.rdy = 1;
        for (int i = 0; i < 4; i++)
            add(v, O_INIT, "mw_init_rdy");
        v = z();
        add(v, O_RUN, "mw_run");
        run_tbl();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
